// File: rtl/acc_pkg.sv
// acc_pkg: shared types and defaults for the MAC-stage adder tree sequencer.
//   seq_state_t  : job sequencer states (IDLE/RUN/DRAIN/DONE)
//   tree_tag_t   : per-beat tag that travels alongside the adder tree data
//   ACC_TREE_LAT : default latency of the registered 4-input adder tree
//   ACC_SHIFT    : default requantization shift
package acc_pkg;

  localparam int ACC_TREE_LAT = 2;
  localparam int ACC_SHIFT    = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tree_tag_t;

endpackage

// File: rtl/acc_out_fifo.sv
// acc_out_fifo: synchronous FIFO with a registered head output.
// The head register always holds the oldest entry, so rdata is valid in the
// same cycle not_empty is high and stays stable until that entry is popped.
// DEPTH must be a power of two, at least 2.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push/wdata write an entry (ignored when full)
//   pop        remove the head entry (ignored when empty)
//   rdata      registered head entry
//   not_empty  FIFO holds at least one entry
module acc_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign not_empty = (count != '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && not_empty;

  always_comb begin
    count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    head_nxt   = rdata;
    // When the FIFO is (or becomes) empty apart from the entry being
    // written this cycle, the new head bypasses the memory.
    if (count_nxt != '0) begin
      if (do_push && (count == (AW+1)'(do_pop)))
        head_nxt = wdata;
      else
        head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      rdata  <= head_nxt;
    end
  end

endmodule

// File: rtl/adder_tree_seq.sv
// adder_tree_seq: sequencer and accumulation controller for the 4-input
// registered adder tree of the MAC stage. Beats of four partial sums are
// issued into the tree, tracked through its fixed latency with a tag pipe,
// accumulated over cfg_groups beats, requantized to int8 and buffered in a
// small output FIFO. Upstream flow control is credit based because the tree
// cannot stall.
// Build option: define ADDER_TREE_SEQ_SAT_EN to saturate the requantized
// value to [-128, 127]; otherwise sign plus low 7 bits are kept.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, cfg_groups,
//   cfg_outputs                job start and configuration (sampled in IDLE)
//   busy, done                 job status
//   in_valid, in_ready,
//   in_psum0..in_psum3         upstream beat handshake and partial sums
//   tree_in1..tree_in4         adder tree inputs (zero when no beat issued)
//   tree_sum                   adder tree result, TREE_LAT cycles later
//   out_valid, out_ready,
//   out_data                   int8 result stream from the output FIFO
module adder_tree_seq
  import acc_pkg::*;
#(
  parameter int TREE_LAT   = ACC_TREE_LAT,
  parameter int ACC_W      = 40,
  parameter int SHIFT      = ACC_SHIFT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cfg_groups,
  input  logic [15:0] cfg_outputs,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_psum0,
  input  logic [31:0] in_psum1,
  input  logic [31:0] in_psum2,
  input  logic [31:0] in_psum3,
  output logic [31:0] tree_in1,
  output logic [31:0] tree_in2,
  output logic [31:0] tree_in3,
  output logic [31:0] tree_in4,
  input  logic [31:0] tree_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  seq_state_t              state;
  logic [7:0]              g_lat;
  logic [15:0]             n_lat;
  logic [7:0]              grp_cnt;
  logic [15:0]             out_cnt;
  logic [15:0]             res_cnt;
  logic [CW-1:0]           credit;
  tree_tag_t               tags [TREE_LAT];
  tree_tag_t               tag_out;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] q;
  logic [7:0]              q8;
  logic                    accept;
  logic                    first_beat;
  logic                    last_beat;
  logic                    reserve;
  logic                    pop;
  logic                    push;

  assign in_ready   = (state == RUN) && (credit != '0);
  assign accept     = in_valid && in_ready;
  assign first_beat = (grp_cnt == 8'd0);
  assign last_beat  = (grp_cnt == g_lat - 8'd1);
  // A FIFO slot is reserved when the first beat of a group enters the tree.
  assign reserve    = accept && first_beat;
  assign pop        = out_valid && out_ready;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  assign tree_in1 = accept ? in_psum0 : '0;
  assign tree_in2 = accept ? in_psum1 : '0;
  assign tree_in3 = accept ? in_psum2 : '0;
  assign tree_in4 = accept ? in_psum3 : '0;

  assign tag_out = tags[TREE_LAT-1];
  assign sum_ext = {{(ACC_W-32){tree_sum[31]}}, tree_sum};
  assign acc_nxt = tag_out.first ? sum_ext : acc + sum_ext;
  assign q       = acc_nxt >>> SHIFT;
  assign push    = tag_out.v && tag_out.last;

`ifdef ADDER_TREE_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

  always_comb begin
    if (q > Q_MAX)
      q8 = 8'h7f;
    else if (q < Q_MIN)
      q8 = 8'h80;
    else
      q8 = q[7:0];
  end
`else
  logic q_unused;

  assign q8       = {q[ACC_W-1], q[6:0]};
  assign q_unused = ^q[ACC_W-2:7];
`endif

  // Job sequencer. Results are counted at the FIFO write so DRAIN ends
  // exactly when the final requantized value lands in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      g_lat   <= 8'd1;
      n_lat   <= '0;
      grp_cnt <= '0;
      out_cnt <= '0;
      res_cnt <= '0;
    end else begin
      if (push)
        res_cnt <= res_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (start) begin
            g_lat   <= (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
            n_lat   <= cfg_outputs;
            grp_cnt <= '0;
            out_cnt <= '0;
            res_cnt <= '0;
            state   <= (cfg_outputs == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_beat) begin
              grp_cnt <= '0;
              out_cnt <= out_cnt + 16'd1;
              if (out_cnt == n_lat - 16'd1)
                state <= DRAIN;
            end else begin
              grp_cnt <= grp_cnt + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (push && (res_cnt == n_lat - 16'd1))
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Credits mirror free FIFO slots including those promised to groups
  // still in flight, so a push can never find the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      credit <= CW'(FIFO_DEPTH);
    else if (reserve && !pop)
      credit <= credit - CW'(1);
    else if (pop && !reserve)
      credit <= credit + CW'(1);
  end

  // Tag pipe matched to the tree latency; clearing it on reset discards
  // whatever data is still inside the tree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++)
        tags[i] <= '0;
    end else begin
      tags[0] <= '{v: accept, first: first_beat, last: last_beat};
      for (int i = 1; i < TREE_LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (tag_out.v)
      acc <= acc_nxt;
  end

  acc_out_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (q8),
    .pop      (pop),
    .rdata    (out_data),
    .not_empty(out_valid)
  );

endmodule

// File: tb/tb_adder_tree_seq.sv
// tb_adder_tree_seq: self-checking bench for adder_tree_seq. A cycle-level
// behavioural model (job phases, credits, expected result queue with
// visibility times) is checked against the DUT on every falling edge, and
// directed jobs pin the model with hand-computed results.
// Honours ADDER_TREE_SEQ_SAT_EN for the expected requantization.
module tb_adder_tree_seq;

  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_groups = '0;
  logic [15:0] cfg_outputs = '0;
  logic        busy;
  logic        done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_psum0 = '0;
  logic [31:0] in_psum1 = '0;
  logic [31:0] in_psum2 = '0;
  logic [31:0] in_psum3 = '0;
  logic [31:0] tree_in1;
  logic [31:0] tree_in2;
  logic [31:0] tree_in3;
  logic [31:0] tree_in4;
  logic [31:0] tree_sum = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;

  // Two-level registered adder tree standing in for the real one.
  logic [31:0] lvl_a = '0;
  logic [31:0] lvl_b = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    lvl_a    <= tree_in1 + tree_in2;
    lvl_b    <= tree_in3 + tree_in4;
    tree_sum <= lvl_a + lvl_b;
  end

  adder_tree_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_groups (cfg_groups),
    .cfg_outputs(cfg_outputs),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_psum0   (in_psum0),
    .in_psum1   (in_psum1),
    .in_psum2   (in_psum2),
    .in_psum3   (in_psum3),
    .tree_in1   (tree_in1),
    .tree_in2   (tree_in2),
    .tree_in3   (tree_in3),
    .tree_in4   (tree_in4),
    .tree_sum   (tree_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int     m_phase = M_IDLE;
  int     m_g = 1;
  int     m_n = 0;
  int     m_beat = 0;
  int     m_outs = 0;
  int     m_final = 0;
  int     m_credit = FD;
  longint m_acc = 0;
  logic [7:0] exp_val[$];
  int         exp_vis[$];

  int         done_seen = 0;
  logic [7:0] popped[$];
  int         first_valid_cyc = -1;
  int         last_accept_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(string name, longint actual, longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  function automatic logic [7:0] quantModel(longint acc_v);
    longint q;
    logic [7:0] r;
    q = acc_v >>> 7;
`ifdef ADDER_TREE_SEQ_SAT_EN
    if (q > 127)
      r = 8'd127;
    else if (q < -128)
      r = 8'h80;
    else
      r = q[7:0];
`else
    r[7]   = (q < 0);
    r[6:0] = q[6:0];
`endif
    return r;
  endfunction

  function automatic int popAt(int i);
    if (i < popped.size())
      return int'(popped[i]);
    return -1;
  endfunction

  // Model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    bit          e_ready;
    bit          e_acc;
    bit          e_ov;
    bit          e_pop;
    logic [31:0] s;
    if (rst) begin
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_tree_in1", tree_in1, 0);
      m_phase = M_IDLE;
      m_credit = FD;
      m_beat = 0;
      m_outs = 0;
      exp_val.delete();
      exp_vis.delete();
    end else begin
      e_ready = (m_phase == M_RUN) && (m_credit > 0);
      e_acc   = in_valid && e_ready;
      e_ov    = (exp_val.size() > 0) && (exp_vis[0] <= cyc);
      e_pop   = e_ov && out_ready;
      checkOutput("in_ready", in_ready, e_ready);
      checkOutput("busy", busy, (m_phase == M_RUN) || (m_phase == M_DRAIN));
      checkOutput("done", done, m_phase == M_DONE);
      checkOutput("out_valid", out_valid, e_ov);
      if (e_ov)
        checkOutput("out_data", out_data, exp_val[0]);
      checkOutput("tree_in1", tree_in1, e_acc ? in_psum0 : 32'd0);
      checkOutput("tree_in2", tree_in2, e_acc ? in_psum1 : 32'd0);
      checkOutput("tree_in3", tree_in3, e_acc ? in_psum2 : 32'd0);
      checkOutput("tree_in4", tree_in4, e_acc ? in_psum3 : 32'd0);
      if (done)
        done_seen++;
      if (out_valid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (e_acc)
        last_accept_cyc = cyc;
      if (e_pop) begin
        popped.push_back(out_data);
        void'(exp_val.pop_front());
        void'(exp_vis.pop_front());
      end
      if (e_acc && m_beat == 0)
        m_credit--;
      if (e_pop)
        m_credit++;
      case (m_phase)
        M_IDLE: begin
          if (start) begin
            m_g = (cfg_groups == 0) ? 1 : int'(cfg_groups);
            m_n = int'(cfg_outputs);
            m_beat = 0;
            m_outs = 0;
            m_phase = (m_n == 0) ? M_DONE : M_RUN;
          end
        end
        M_RUN: begin
          if (e_acc) begin
            s = in_psum0 + in_psum1 + in_psum2 + in_psum3;
            m_acc = (m_beat == 0) ? longint'($signed(s)) : m_acc + longint'($signed(s));
            m_beat++;
            if (m_beat == m_g) begin
              m_beat = 0;
              exp_val.push_back(quantModel(m_acc));
              exp_vis.push_back(cyc + LAT + 1);
              m_outs++;
              if (m_outs == m_n) begin
                m_phase = M_DRAIN;
                m_final = cyc + LAT;
              end
            end
          end
        end
        M_DRAIN: if (cyc == m_final) m_phase = M_DONE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    popped.delete();
    done_seen = 0;
    first_valid_cyc = -1;
    last_accept_cyc = -1;
  endtask

  task automatic startJob(input int g, input int n);
    cfg_groups  = 8'(g);
    cfg_outputs = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic driveLanes(input logic [31:0] v);
    in_psum0 = v;
    in_psum1 = v + 32'd1;
    in_psum2 = v + 32'd2;
    in_psum3 = v - 32'd3;
  endtask

  // Beat idx carries lanes {v, v+1, v+2, v-3} with v = base + step*idx,
  // so every beat sums to 4*v while the lanes stay distinguishable.
  task automatic applyStimulus(input int start_idx, input int n_beats, input int base,
                               input int step, input int max_cycles,
                               output int accepted, output int cycles);
    bit got;
    accepted = 0;
    cycles = 0;
    driveLanes(32'(base + step * start_idx));
    in_valid = 1'b1;
    while (accepted < n_beats && cycles < max_cycles) begin
      @(negedge clk);
      got = in_ready;
      tick();
      cycles++;
      if (got) begin
        accepted++;
        driveLanes(32'(base + step * (start_idx + accepted)));
      end
    end
    in_valid = 1'b0;
    driveLanes(32'd0);
    in_psum1 = '0;
    in_psum2 = '0;
    in_psum3 = '0;
  endtask

  task automatic waitIdle(input int limit);
    int i;
    i = 0;
    while (!(m_phase == M_IDLE && exp_val.size() == 0) && i < limit) begin
      tick();
      i++;
    end
    checkOutput("job_finished_in_time", (m_phase == M_IDLE && exp_val.size() == 0), 1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int acc_n;
    int cyc_n;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    out_ready = 1'b1;

    $display("[TB] G=1 N=1, psums 128");
    clearLog();
    startJob(1, 1);
    applyStimulus(0, 1, 128, 0, 20, acc_n, cyc_n);
    waitIdle(50);
    checkOutput("g1n1_value", popAt(0), 4);
    checkOutput("g1n1_count", popped.size(), 1);
    checkOutput("g1n1_latency", first_valid_cyc - last_accept_cyc, 3);
    checkOutput("g1n1_done", done_seen, 1);

    $display("[TB] G=3 N=2, psums 256");
    clearLog();
    startJob(3, 2);
    applyStimulus(0, 6, 256, 0, 30, acc_n, cyc_n);
    checkOutput("g3n2_back_to_back", cyc_n, 6);
    waitIdle(50);
    checkOutput("g3n2_value0", popAt(0), 24);
    checkOutput("g3n2_value1", popAt(1), 24);
    checkOutput("g3n2_done", done_seen, 1);

    $display("[TB] N=6 G=1 with downstream stalled");
    clearLog();
    out_ready = 1'b0;
    startJob(1, 6);
    applyStimulus(0, 6, 128, 128, 10, acc_n, cyc_n);
    checkOutput("credit_stall_accepts", acc_n, 4);
    out_ready = 1'b1;
    applyStimulus(4, 2, 128, 128, 30, acc_n, cyc_n);
    checkOutput("credit_resume_accepts", acc_n, 2);
    waitIdle(60);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("credit_order_%0d", i), popAt(i), 4 * (i + 1));
    checkOutput("credit_done", done_seen, 1);

    $display("[TB] large and negative psums");
    clearLog();
    startJob(1, 2);
    applyStimulus(0, 2, 65536, -65792, 20, acc_n, cyc_n);
    waitIdle(50);
`ifdef ADDER_TREE_SEQ_SAT_EN
    checkOutput("large_sat", popAt(0), 127);
`else
    checkOutput("large_trunc", popAt(0), 0);
`endif
    checkOutput("negative_shift", popAt(1), 248);

    $display("[TB] cfg_groups=0 and cfg_outputs=0");
    clearLog();
    startJob(0, 1);
    applyStimulus(0, 1, 128, 0, 20, acc_n, cyc_n);
    waitIdle(50);
    checkOutput("g0_as_g1", popAt(0), 4);
    clearLog();
    startJob(3, 0);
    waitIdle(20);
    checkOutput("n0_done", done_seen, 1);
    checkOutput("n0_no_output", popped.size(), 0);

    $display("[TB] reset with results in flight");
    clearLog();
    startJob(1, 4);
    applyStimulus(0, 2, 256, 0, 10, acc_n, cyc_n);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    checkOutput("abort_no_stale", popped.size(), 0);
    checkOutput("abort_busy", busy, 0);
    clearLog();
    startJob(1, 1);
    applyStimulus(0, 1, 128, 0, 20, acc_n, cyc_n);
    waitIdle(50);
    checkOutput("after_abort_value", popAt(0), 4);
    checkOutput("after_abort_done", done_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder_tree_seq.md
# adder_tree_seq

Sequencer and accumulation controller for the 4-input registered adder tree (two adder32 levels, 32-bit signed) used by the accelerator's MAC stage. It accepts four partial sums per beat from the conv engine, issues them into the tree, and tracks results through the tree's fixed latency with a valid/tag pipeline. It accumulates `cfg_groups` beats per output, requantizes each output to int8, and buffers results in a small output FIFO. Because the tree cannot stall, upstream backpressure is credit-based.

## Interface
- `TREE_LAT`, 2: tree latency in cycles, from inputs presented to `tree_sum` valid.
- `ACC_W`, 40: accumulator width; signed.
- `SHIFT`, 7: arithmetic right shift applied before int8 conversion.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `cfg_groups`  in  8  beats per output; latched at start; 0 is treated as 1.
- `cfg_outputs`  in  16  outputs per job; latched at start.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the job completes.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_psum0`..`in_psum3`  in  32 each  signed partial sums.
- `tree_in1`..`tree_in4`  out  32 each  to tree inputs.
- `tree_sum`  in  32  tree result.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream pop.
- `out_data`  out  8  signed int8 result at the FIFO head.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start`, latch the config and clear the counters. Go to DONE if `cfg_outputs==0`, otherwise to RUN.
  - RUN: accept beats. Go to DRAIN in the cycle the beat with global index `G*N-1` is accepted.
  - DRAIN: `in_ready=0`. Go to DONE in the cycle the last result is written to the FIFO.
  - DONE: `done=1` for one cycle, then IDLE. `start` outside IDLE is ignored.
- `in_ready = (state==RUN) && credit>0`.
- Counters: `grp_cnt` runs 0..G-1 and wraps; `out_cnt` counts issued outputs.
- Credit: starts at FIFO_DEPTH.
  - Decrement when a beat with `grp_cnt==0` is accepted (slot reserved).
  - Increment on each FIFO pop.
  - A same-cycle reserve and pop leaves credit unchanged.
  - The FIFO can never overflow.
- Tree issue:
  - `tree_inK` equals `in_psum(K-1)` in the accept cycle, otherwise 0.
  - A tag `{v, first, last}` enters a TREE_LAT-deep shift register: `first = grp_cnt==0`, `last = grp_cnt==G-1`.
- Accumulate when the tag output `v` is high:
  - `acc = first ? sext(tree_sum) : acc + sext(tree_sum)`.
  - If `last`, push `quant(acc_next)` to the FIFO.
- Quantization: `q = acc_next >>> SHIFT`. Result without saturation is `{q[ACC_W-1], q[6:0]}`.
- Output FIFO: simultaneous push and pop allowed; pop when `out_valid && out_ready`.

## Timing
- Reset values: `in_ready=0`, `busy=0`, `done=0`, `out_valid=0`, `out_data=0`, `tree_in*=0`. On reset, state goes to IDLE, counters clear, credit is FIFO_DEPTH, and all tags clear.
- Reset mid-job aborts the job. In-flight tree data is discarded because the tags are cleared.
- Beat accepted at cycle t: `tree_sum` is valid at t+TREE_LAT.
  - For a `last` beat, the FIFO write is at the end of t+TREE_LAT.
  - With an empty FIFO, `out_valid` rises at t+TREE_LAT+1 (3 cycles with defaults).
- Back-to-back beats are accepted at 1 per cycle while credit>0.
- `done` is asserted the cycle after the final FIFO write; `busy` drops in the same cycle.
- `out_data` is registered from the FIFO head and is stable while `out_valid && !out_ready`.

## Configuration
- `ADDER_TREE_SEQ_SAT_EN` defined: `q` clamps to [-128, 127] before conversion to 8 bits.
- Undefined: the plain sign-plus-low-7-bits truncation above, with no clamping.

## Structure
- Shared package `acc_pkg`:
  - state enum `seq_state_t` (IDLE/RUN/DRAIN/DONE);
  - tag struct `tree_tag_t` {v, first, last};
  - defaults `ACC_TREE_LAT=2`, `ACC_SHIFT=7`.
- Sub-module `acc_out_fifo`: synchronous FIFO, parameterized width and depth, with registered head output. Everything else lives in `adder_tree_seq`.

## Test plan
- G=1, N=1; psums 128,128,128,128 -> `out_data=4` (512>>>7), `out_valid` 3 cycles after accept, then `done`.
- G=3, N=2; every psum 256 -> two outputs of 24 (3072>>>7), accepted back-to-back, one `done`.
- N=6, G=1, FIFO_DEPTH=4, `out_ready=0` -> `in_ready` drops after 4 accepts. Raising `out_ready` resumes the job; all 6 outputs arrive in order.
- Psums 65536 each, G=1:
  - with `ADDER_TREE_SEQ_SAT_EN` -> 127;
  - without -> `{0, q[6:0]}`=0 (2048 has bits [6:0]=0).
- Psums -256 each -> -8 (0xF8); checks arithmetic shift and sign.
- Assert `rst` mid-job with 2 outputs in flight -> all outputs go to their reset values, no stale FIFO write afterwards. A new `start` completes correctly.
